// File: rtl/inst_mem_loader.sv
// inst_mem_loader: byte-stream loadable instruction memory with a 32-bit fetch port.
// A host streams bytes over valid/ready. They are stored little-endian from
// address 0. The core is halted and sees NOPs until the load completes.
module inst_mem_loader #(
  parameter int          DEPTH = 88,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [7:0]  load_len,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        load_busy,
  output logic        cpu_halt,
  output logic        load_done,
  output logic        load_err,
  output logic [9:0]  load_count,
  input  logic [7:0]  inst_address,
  output logic [31:0] instruction
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0] DEPTH_L = 10'(DEPTH);
  localparam logic [8:0] DEPTH_A = 9'(DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state_q, state_d;
  logic [9:0]  total_q, total_d;
  logic [8:0]  wr_ptr_q, wr_ptr_d;
  logic [9:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wr_en;
  logic [9:0]  total_req;
  logic [7:0]  mem_q [DEPTH];
  logic [31:0] fetch_word;
  logic [8:0]  fetch_addr;

  // Next-state logic: start validation in IDLE, byte acceptance and completion in LOAD.
  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_en     = 1'b0;
    total_req = {load_len, 2'b00};
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_len == 8'd0 || total_req > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            total_d  = total_req;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (byte_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 9'd1;
          count_d  = count_q + 10'd1;
          if ({1'b0, wr_ptr_q} == total_q - 10'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; synchronous active-low reset aborts any load in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      total_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Byte storage; reset clears the whole array so aborted loads leave no residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= byte_in;
    end
  end

  // Little-endian fetch; 9-bit address math so bytes past the end read as zero instead of wrapping.
  always_comb begin
    fetch_word = '0;
    fetch_addr = '0;
    for (int k = 0; k < 4; k++) begin
      fetch_addr = {1'b0, inst_address} + 9'(k);
      if (fetch_addr < DEPTH_A) fetch_word[8*k +: 8] = mem_q[fetch_addr[AW-1:0]];
    end
  end

  assign instruction = (state_q == LOAD) ? NOP : fetch_word;
  assign load_busy   = (state_q == LOAD);
  assign cpu_halt    = load_busy;
  assign byte_ready  = load_busy;
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign load_count  = count_q;

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writable, byte-addressed instruction memory with a byte-stream load port, the write-side counterpart of the processor's read-only fetch memory. A host streams program bytes over a valid/ready handshake. The block assembles them little-endian into memory, with byte 0 of an instruction at the lowest address. While loading, it holds the core in halt and feeds it NOPs. Once the load completes, the same 32-bit fetch interface serves the core unchanged.

## Interface
- `DEPTH`, default 88: memory size in bytes; must be a multiple of 4 and ≤ 256.
- `NOP`, default `32'h00000013`: instruction word returned while loading (ADDI x0, x0, 0).
- `clk` in, 1: single clock; all state changes on the rising edge.
- `rst_n` in, 1: reset is synchronous and active-low.
- `load_start` in, 1: request a new load; sampled only in IDLE.
- `load_len` in, 8: number of 32-bit instructions to load; sampled with `load_start`.
- `byte_in` in, 8: program byte.
- `byte_valid` in, 1: `byte_in` is valid.
- `byte_ready` out, 1: block accepts a byte this cycle.
- `load_busy` out, 1: high in LOAD.
- `cpu_halt` out, 1: equal to `load_busy`.
- `load_done` out, 1: one-cycle pulse when the last byte has been written.
- `load_err` out, 1: one-cycle pulse when a `load_start` is rejected.
- `load_count` out, 10: bytes accepted in the current or most recent load.
- `inst_address` in, 8: fetch byte address.
- `instruction` out, 32: fetched word.

## Operation
- **States:** IDLE, LOAD.
- **Reset (`rst_n` = 0 at an edge):**
  - state → IDLE.
  - All memory bytes → 0.
  - `load_count` → 0.
  - `wr_ptr` → 0.
  - `byte_ready`, `load_busy`, `cpu_halt`, `load_done`, `load_err` → 0.
  - A reset during LOAD aborts the load and no `load_done` is issued.
- **IDLE, start handling:** on `load_start` = 1, compute `total = 4*load_len` in 10 bits, so there is no overflow for `load_len` = 255.
  - If `load_len` = 0 or `total` > `DEPTH`: pulse `load_err`, stay in IDLE, leave memory untouched.
  - Otherwise: latch `total`, set `wr_ptr` = 0 and `load_count` = 0, and go to LOAD.
- **IDLE, default outputs:** `byte_ready` = 0; bytes presented are ignored.
- **LOAD, handshake:** `byte_ready` = 1. A byte is accepted when `byte_valid && byte_ready` at an edge.
  - On acceptance: write `mem[wr_ptr]` = `byte_in`, increment `wr_ptr`, increment `load_count`.
  - `byte_valid` = 0 stalls without penalty. The host may change `byte_in` freely while `byte_valid` = 0.
- **LOAD, completion:** when the accepted byte is number `total` (`wr_ptr` = `total`−1), go to IDLE and pulse `load_done`.
  - Bytes above `total` keep their previous contents.
  - `load_start` during LOAD is ignored and does not raise `load_err`.
- **Fetch (combinational):** `instruction = {mem[a+3], mem[a+2], mem[a+1], mem[a]}` with `a = inst_address`.
  - Any byte whose address is ≥ `DEPTH` reads as 0, so a partially out-of-range word returns zero in the missing bytes.
  - Address arithmetic uses 9 bits, so `a+3` does not wrap to 0.
- **Fetch while loading:** in LOAD, `instruction` = `NOP` regardless of address.

## Timing
- **Start:** `load_start` sampled at edge N → `load_busy`, `cpu_halt` and `byte_ready` high from N+1. The first byte can be accepted at edge N+1.
- **Throughput:** one byte per cycle maximum. A 4·L-byte load takes ≥ 4·L cycles after entry.
- **Write visibility:** a byte accepted at edge M is present in `mem` after M, but `instruction` shows `NOP` until the load ends.
- **End of load:** last byte accepted at edge M → `load_busy` and `byte_ready` low, `load_done` high, during cycle M+1 only. `instruction` reflects the new contents from M+1.
- **Rejection:** `load_err` is high for exactly the cycle after the rejected `load_start` edge.
- **Back-to-back loads:** `load_start` held high through completion starts a new load at the first IDLE edge, i.e. the cycle in which `load_done` is high.
- **Reset vs. start:** reset has priority over any simultaneous `load_start` or byte acceptance.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles → all outputs 0; `instruction` = `32'h0` at addresses 0 and 84; `load_count` = 0.
- **Two-word load:** `load_start`, `load_len` = 2, then stream bytes `93 00 50 00 13 01 A0 00`, each with `byte_valid`.
  - `load_done` pulses one cycle after the 8th byte.
  - Reading address 0 gives `32'h00500093`; address 4 gives `32'h00A00113`.
  - `instruction` = `32'h00000013` throughout the load.
- **Stalled handshake:** same load with `byte_valid` toggling 1/0 every cycle → identical memory contents; `load_count` = 8; completion 16 cycles after entry.
- **Rejected starts:** `load_len` = 0 → `load_err` pulse, no state change. `load_len` = 23 with `DEPTH` = 88 → `load_err`. `load_len` = 22 → accepted, and the 88th byte triggers `load_done`.
- **Reset mid-load:** `load_len` = 4, assert reset after 5 bytes → IDLE, no `load_done`, memory all 0, `byte_ready` = 0.
- **Edge fetch:** after a full 88-byte load of pattern `mem[i] = i`, `inst_address` = 84 gives `32'h57565554`; `inst_address` = 86 gives `32'h00005756`.
